// File: rtl/wb_arbiter_pkg.sv
// core_pkg: register-file widths and the write-back entry shared by the arbiter files.
package core_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
    typedef struct packed {
        logic [XLEN-1:0]       data;
        logic [REG_ADDR_W-1:0] rd;
    } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: functional-unit result handshakes plus the regbank write port.
// WB_ARB_PERF_EN adds the perf_writes/perf_stall counter outputs.
interface wb_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W = 32
);
    import core_pkg::*;
    localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    logic [NUM_SRC-1:0]                 fu_valid;
    logic [NUM_SRC-1:0]                 fu_ready;
    logic [NUM_SRC-1:0][DATA_W-1:0]     fu_data;
    logic [NUM_SRC-1:0][REG_ADDR_W-1:0] fu_rd;
    logic [DATA_W-1:0]                  write_data;
    logic [REG_ADDR_W-1:0]              write_address;
    logic [SW-1:0]                      grant_src;
`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_writes;
    logic [31:0] perf_stall;
    modport master (
        output fu_valid, fu_data, fu_rd,
        input  fu_ready, write_data, write_address, grant_src, perf_writes, perf_stall
    );
    modport slave (
        input  fu_valid, fu_data, fu_rd,
        output fu_ready, write_data, write_address, grant_src, perf_writes, perf_stall
    );
`else
    modport master (
        output fu_valid, fu_data, fu_rd,
        input  fu_ready, write_data, write_address, grant_src
    );
    modport slave (
        input  fu_valid, fu_data, fu_rd,
        output fu_ready, write_data, write_address, grant_src
    );
`endif
endinterface

// File: rtl/wb_arbiter_src_fifo.sv
// wb_src_fifo: per-source in-order result buffer of DEPTH (power of two) entries.
module wb_src_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter type T = wb_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  T                       i_data,
    output T                       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= i_push ? r_wr + AW'(1) : r_wr;
            r_rd    <= i_pop ? r_rd + AW'(1) : r_rd;
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end
    assign o_head  = r_mem[r_rd];
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: buffers NUM_SRC result streams and round-robins them onto the single regbank write port.
// Define WB_ARB_PERF_EN to add the perf_writes/perf_stall counters.
module wb_arbiter
    import core_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DEPTH = 2,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    wb_arbiter_if.slave   bus
);
    localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [REG_ADDR_W-1:0] rd;
    } entry_t;

    logic [NUM_SRC-1:0] w_ready;
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;
    logic [NUM_SRC-1:0] w_full;
    logic [NUM_SRC-1:0] w_empty;
    logic [CW-1:0]      w_count [NUM_SRC];
    entry_t             w_in    [NUM_SRC];
    entry_t             w_head  [NUM_SRC];
    logic               w_found;
    logic [SW-1:0]      w_win;

    logic [DATA_W-1:0]     r_data;
    logic [REG_ADDR_W-1:0] r_addr;
    logic [SW-1:0]         r_grant;
    logic [SW-1:0]         r_ptr;

    function automatic logic [SW-1:0] rr_idx(input logic [SW-1:0] base, input int k);
        return SW'((int'(base) + k) % NUM_SRC);
    endfunction

    // rd = 0 results complete the handshake but are never enqueued.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign w_ready[g] = !reset && (w_count[g] < CW'(DEPTH));
        assign w_push[g]  = bus.fu_valid[g] && w_ready[g] && !w_full[g] && (bus.fu_rd[g] != REG_ZERO);
        assign w_in[g]    = {bus.fu_data[g], bus.fu_rd[g]};
        wb_src_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_data  (w_in[g]),
            .o_head  (w_head[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_count (w_count[g])
        );
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!w_found && !w_empty[rr_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = rr_idx(r_ptr, k);
            end
        end
        w_pop = w_found ? (NUM_SRC'(1) << w_win) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_addr  <= REG_ZERO;
            r_grant <= '0;
            r_ptr   <= '0;
        end else if (w_found) begin
            r_data  <= w_head[w_win].data;
            r_addr  <= w_head[w_win].rd;
            r_grant <= w_win;
            r_ptr   <= rr_idx(w_win, 1);
        end else begin
            r_addr  <= REG_ZERO;
            r_grant <= '0;
        end
    end

    assign bus.fu_ready      = w_ready;
    assign bus.write_data    = r_data;
    assign bus.write_address = r_addr;
    assign bus.grant_src     = r_grant;

`ifdef WB_ARB_PERF_EN
    logic [31:0] r_perf_writes;
    logic [31:0] r_perf_stall;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_writes <= '0;
            r_perf_stall  <= '0;
        end else begin
            r_perf_writes <= r_perf_writes + 32'(r_addr != REG_ZERO);
            r_perf_stall  <= r_perf_stall + 32'(|(bus.fu_valid & ~w_ready));
        end
    end
    assign bus.perf_writes = r_perf_writes;
    assign bus.perf_stall  = r_perf_stall;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vectors with hand-computed expectations plus a per-source scoreboard for backpressure.
module tb_wb_arbiter;
    import core_pkg::*;
    localparam int N = 4;
    localparam int D = 2;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.NUM_SRC(N), .DATA_W(W)) bus ();
    wb_arbiter #(.NUM_SRC(N), .DEPTH(D), .DATA_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [W+4:0] sb [N][$];
    logic [W+4:0] e;
    logic [N-1:0] exp_rdy;
    logic         saw_full0;
    int           g;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.fu_valid = '0;
        bus.fu_data  = '0;
        bus.fu_rd    = '0;
    endtask

    initial begin
        idle_inputs();
        bus.fu_valid = 4'hF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_ready", bus.fu_ready, 0);
            check("rst_waddr", bus.write_address, 0);
        end
        check("rst_wdata", bus.write_data, 0);
        check("rst_grant", bus.grant_src, 0);
        bus.fu_valid = '0;
        reset = 1'b0;
        #1;
        check("ready_after_rst", bus.fu_ready, 4'hF);

        for (int i = 0; i < N; i++) begin
            bus.fu_rd[i]   = 5'(i + 1);
            bus.fu_data[i] = 32'h100 + 32'(i);
        end
        bus.fu_valid = 4'hF;
        tick();
        idle_inputs();
        check("cont_latency", bus.write_address, 0);
        for (int i = 0; i < N; i++) begin
            tick();
            check("cont_rd", bus.write_address, 64'(i + 1));
            check("cont_data", bus.write_data, 64'h100 + 64'(i));
            check("cont_grant", bus.grant_src, 64'(i));
        end
        tick();
        check("cont_idle", bus.write_address, 0);

        bus.fu_valid   = 4'b1001;
        bus.fu_rd[0]   = 5'd9;
        bus.fu_data[0] = 32'hAA;
        bus.fu_rd[3]   = 5'd10;
        bus.fu_data[3] = 32'hBB;
        tick();
        idle_inputs();
        tick();
        check("ptr_first_rd", bus.write_address, 9);
        check("ptr_first_grant", bus.grant_src, 0);
        tick();
        check("ptr_second_rd", bus.write_address, 10);
        check("ptr_second_data", bus.write_data, 64'hBB);
        check("ptr_second_grant", bus.grant_src, 3);
        tick();
        check("ptr_idle", bus.write_address, 0);

        bus.fu_valid   = 4'b0100;
        bus.fu_rd[2]   = 5'd5;
        bus.fu_data[2] = 32'd255;
        tick();
        idle_inputs();
        check("single_latency", bus.write_address, 0);
        tick();
        check("single_rd", bus.write_address, 5);
        check("single_data", bus.write_data, 255);
        check("single_grant", bus.grant_src, 2);
        tick();
        check("single_idle", bus.write_address, 0);
        check("single_idle_grant", bus.grant_src, 0);
        check("single_data_hold", bus.write_data, 255);

        bus.fu_valid   = 4'b0010;
        bus.fu_rd[1]   = 5'd0;
        bus.fu_data[1] = 32'hDEAD;
        #1;
        check("drop_ready", bus.fu_ready[1], 1);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drop_waddr", bus.write_address, 0);
            check("drop_grant", bus.grant_src, 0);
        end

        saw_full0 = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (bus.write_address != 0) begin
                g = int'(bus.grant_src);
                check("sb_has_entry", sb[g].size() != 0, 1);
                if (sb[g].size() != 0) begin
                    e = sb[g].pop_front();
                    check("sb_data", bus.write_data, e[W+4:5]);
                    check("sb_rd", bus.write_address, e[4:0]);
                end
            end
            for (int i = 0; i < N; i++) exp_rdy[i] = sb[i].size() < D;
            check("bp_ready", bus.fu_ready, exp_rdy);
            if (!exp_rdy[0]) saw_full0 = 1'b1;
            idle_inputs();
            if (cyc < 16) begin
                for (int i = 0; i < N; i++) begin
                    bus.fu_valid[i] = 1'b1;
                    bus.fu_rd[i]    = (i == 0) ? 5'd7 : 5'(8 + i);
                    bus.fu_data[i]  = {16'(i), 16'(cyc)};
                    if (exp_rdy[i]) sb[i].push_back({bus.fu_data[i], bus.fu_rd[i]});
                end
            end
            tick();
        end
        for (int i = 0; i < N; i++) check("sb_drained", sb[i].size(), 0);
        check("bp_src0_filled", saw_full0, 1);

        for (int i = 0; i < N; i++) begin
            bus.fu_rd[i]   = 5'(11 + i);
            bus.fu_data[i] = 32'h500 + 32'(i);
        end
        bus.fu_valid = 4'hF;
        tick();
        idle_inputs();
        tick();
        check("ar_pre_busy", bus.write_address != 0, 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_waddr", bus.write_address, 0);
        check("ar_grant", bus.grant_src, 0);
        check("ar_ready", bus.fu_ready, 0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("ar_post_waddr", bus.write_address, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
